encrypt_sequencer: RTL
======================

# encrypt_sequencer

Hardware sequencer for the Program #1 message-encryption datapath. It sits between the top-level Start/Ack handshake and the single data-memory port. It reads the run configuration from memory (pre-length at 61, LFSR pattern index at 62, LFSR seed at 63) and walks all 64 padded character positions. For each position it steps the 7-bit LFSR and writes the parity-tagged ciphertext to addresses 64..127.

## Interface
- NUM_CHARS, 64: padded message positions processed per run
- MSG_MAX, 49: maximum message length; source addresses 0..MSG_MAX-1
- OUT_BASE, 64: first ciphertext address
- Clk  input  1  rising-edge clock
- Reset  input  1  reset; asynchronous, active-low (0 = reset)
- Start  input  1  run request; held 1 to park, run launches when it falls
- Ack  output  1  run complete; stays high until the next Start
- MemAddr  output  8  data-memory address
- MemWrEn  output  1  data-memory write enable
- MemWrData  output  8  data-memory write data
- MemRdData  input  8  combinational read data, Core[MemAddr] in the same cycle

## Operation
- States: IDLE, CFG0, CFG1, CFG2, RD, WR, DONE.
- Launch: in IDLE, the launch edge is the first rising edge where Start=0 and the previous sampled Start=1. That edge moves the FSM to CFG0.
- CFG0: MemAddr=61, latch pre_len = MemRdData.
- CFG1: MemAddr=62, latch taps from pattern table index MemRdData[3:0].
  - Pattern table: 0:0x60, 1:0x48, 2:0x78, 3:0x72, 4:0x6A, 5:0x69, 6:0x5C, 7:0x7E, 8:0x7B.
  - Any index above 8 (including a nonzero upper nibble) selects entry 0.
- CFG2: MemAddr=63, latch lfsr = MemRdData[6:0]; a value of 0 is forced to 0x01. Clear i=0.
- RD (position i):
  - src = i - pre_len, computed 9-bit signed.
  - If 0 <= src < MSG_MAX: MemAddr = src and pad = MemRdData is latched.
  - Otherwise: MemAddr = 0 and pad = 0x20.
  - MemWrEn=0.
- WR (position i):
  - MemAddr = OUT_BASE+i and MemWrEn=1.
  - MemWrData[6:0] = pad[6:0] ^ lfsr; MemWrData[7] = XOR-reduce of MemWrData[6:0].
  - On the edge: lfsr <= {lfsr[5:0], ^(lfsr & taps)} and i <= i+1.
  - If i==63 go to DONE, else go to RD.
- DONE: Ack=1. Start=1 sampled moves the FSM to IDLE. Start=0 keeps it in DONE; no relaunch without a new 1->0 transition.
- MemWrEn is 1 only in WR. No memory writes outside 64..127.
- i is a 6-bit counter; it does not wrap within a run.

## Timing
- Reset values: Ack=0, MemWrEn=0, MemAddr=0, MemWrData=0, state=IDLE, i=0, lfsr=0x01, taps=0x60, pre_len=0.
- Reset asserted mid-run aborts immediately, with no further writes. Bytes already written stay in memory.
- Let E0 be the launch edge. After E0+k the FSM is in:
  - k=0: CFG0; k=1: CFG1; k=2: CFG2.
  - RD of position i at k=3+2i; WR of position i at k=4+2i.
  - DONE at k=131, when Ack rises.
- Fixed 131-cycle latency from E0 to Ack, independent of pre_len and message content.
- A write commits at the rising edge that ends its WR cycle. Last write (addr 127) commits at E0+131, the same edge Ack rises.
- Start toggling during CFG/RD/WR is ignored.
- Ack falls at the first edge after Start is sampled 1 in DONE.
- pre_len >= 64 gives all-space plaintext, which is legal. pre_len between 16 and 63 truncates the message tail and is legal.

## Test plan
- Nominal: pre_len=10, pt_no=0, seed=0x01, message "Mr. Watson, come here. I want to see you." -> LFSR 01,02,04,08,10,20,41,03,...; Core[64]=0x21, Core[65]=0x22, Core[70]=0xE1. All 64 bytes match the reference model. Ack at E0+131.
- Zero pre-length: pre_len=0, pt_no=0, seed=0x01, Core[0]='M' (0x4D) -> Core[64]=0xCC.
- Illegal config: seed=0x00 and pt_no=9 -> output identical to the nominal run (seed forced to 0x01, taps 0x60).
- Large pre-length: pre_len=200 -> every output is 0x20^lfsr with parity. No reads from 0..48 (MemAddr never in 1..48 during RD).
- Reset mid-run: assert Reset=0 at E0+50 -> Ack=0, MemWrEn=0 in the same cycle, no further writes. Release and relaunch -> full correct 64-byte result.
- Handshake: hold Start=0 in DONE for 10 cycles -> Ack stays 1, no relaunch. Start=1 -> Ack=0 next edge. Start falls again -> second run, identical output.

Source files
------------

// File: rtl/encrypt_sequencer.sv
// Sequencer for the message-encryption datapath: reads run configuration, then
// walks 64 padded positions, stepping a 7-bit LFSR and writing parity-tagged ciphertext.
module encrypt_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    input  logic [7:0] MemRdData
);

    localparam int unsigned NUM_CHARS = 64;
    localparam int unsigned MSG_MAX   = 49;
    localparam int unsigned OUT_BASE  = 64;
    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 8;
    localparam int unsigned LW        = 7;
    localparam int unsigned IW        = 6;
    localparam int unsigned SW        = 9;

    localparam logic [AW-1:0] ADDR_PRE_LEN = 8'd61;
    localparam logic [AW-1:0] ADDR_PT_NO   = 8'd62;
    localparam logic [AW-1:0] ADDR_SEED    = 8'd63;
    localparam logic [DW-1:0] SPACE        = 8'h20;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CFG0 = 3'd1;
    localparam logic [2:0] S_CFG1 = 3'd2;
    localparam logic [2:0] S_CFG2 = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]    r_state;
    logic          r_start_d;
    logic [DW-1:0] r_pre_len;
    logic [LW-1:0] r_taps;
    logic [LW-1:0] r_lfsr;
    logic [IW-1:0] r_i;
    logic          r_ack;
    logic [AW-1:0] r_addr;
    logic          r_wr_en;
    logic [DW-1:0] r_wr_data;

    logic [2:0]    w_state_nxt;
    logic [DW-1:0] w_pre_len_nxt;
    logic [LW-1:0] w_taps_nxt;
    logic [LW-1:0] w_lfsr_nxt;
    logic [IW-1:0] w_i_nxt;
    logic          w_ack_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic          w_wr_en_nxt;
    logic [DW-1:0] w_wr_data_nxt;

    logic [IW-1:0] w_rd_i;
    logic [SW-1:0] w_nxt_src;
    logic          w_nxt_ok;
    logic [SW-1:0] w_cur_src;
    logic          w_cur_ok;
    logic [DW-1:0] w_pad;
    logic [LW-1:0] w_cipher;
    logic [LW-1:0] w_tap_sel;

    assign Ack       = r_ack;
    assign MemAddr   = r_addr;
    assign MemWrEn   = r_wr_en;
    assign MemWrData = r_wr_data;

    // Source position is i - pre_len in 9-bit two's complement; only 0..MSG_MAX-1 reads memory.
    assign w_rd_i    = (r_state == S_WR) ? IW'(r_i + 1'b1) : '0;
    assign w_nxt_src = SW'(w_rd_i) - SW'(r_pre_len);
    assign w_nxt_ok  = !w_nxt_src[SW-1] && (w_nxt_src[AW-1:0] < AW'(MSG_MAX));
    assign w_cur_src = SW'(r_i) - SW'(r_pre_len);
    assign w_cur_ok  = !w_cur_src[SW-1] && (w_cur_src[AW-1:0] < AW'(MSG_MAX));

    assign w_pad    = w_cur_ok ? MemRdData : SPACE;
    assign w_cipher = w_pad[LW-1:0] ^ r_lfsr;

    // Tap pattern table; any out-of-range index (incl. nonzero upper nibble) maps to entry 0.
    always_comb begin
        w_tap_sel = 7'h60;
        case (MemRdData)
            8'd1:    w_tap_sel = 7'h48;
            8'd2:    w_tap_sel = 7'h78;
            8'd3:    w_tap_sel = 7'h72;
            8'd4:    w_tap_sel = 7'h6A;
            8'd5:    w_tap_sel = 7'h69;
            8'd6:    w_tap_sel = 7'h5C;
            8'd7:    w_tap_sel = 7'h7E;
            8'd8:    w_tap_sel = 7'h7B;
            default: w_tap_sel = 7'h60;
        endcase
    end

    // Next-state and registered-output logic; memory address is set up one edge ahead.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_len_nxt = r_pre_len;
        w_taps_nxt    = r_taps;
        w_lfsr_nxt    = r_lfsr;
        w_i_nxt       = r_i;
        w_ack_nxt     = 1'b0;
        w_addr_nxt    = '0;
        w_wr_en_nxt   = 1'b0;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            S_IDLE: begin
                if (!Start && r_start_d) begin
                    w_state_nxt = S_CFG0;
                    w_addr_nxt  = ADDR_PRE_LEN;
                end
            end
            S_CFG0: begin
                w_pre_len_nxt = MemRdData;
                w_state_nxt   = S_CFG1;
                w_addr_nxt    = ADDR_PT_NO;
            end
            S_CFG1: begin
                w_taps_nxt  = w_tap_sel;
                w_state_nxt = S_CFG2;
                w_addr_nxt  = ADDR_SEED;
            end
            S_CFG2: begin
                w_lfsr_nxt  = (MemRdData[LW-1:0] == '0) ? 7'h01 : MemRdData[LW-1:0];
                w_i_nxt     = '0;
                w_state_nxt = S_RD;
                w_addr_nxt  = w_nxt_ok ? w_nxt_src[AW-1:0] : '0;
            end
            S_RD: begin
                w_state_nxt   = S_WR;
                w_addr_nxt    = AW'(OUT_BASE) + AW'(r_i);
                w_wr_en_nxt   = 1'b1;
                w_wr_data_nxt = {^w_cipher, w_cipher};
            end
            S_WR: begin
                w_lfsr_nxt = {r_lfsr[LW-2:0], ^(r_lfsr & r_taps)};
                if (r_i == IW'(NUM_CHARS - 1)) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                end else begin
                    w_i_nxt     = w_rd_i;
                    w_state_nxt = S_RD;
                    w_addr_nxt  = w_nxt_ok ? w_nxt_src[AW-1:0] : '0;
                end
            end
            S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ack_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_pre_len <= '0;
            r_taps    <= 7'h60;
            r_lfsr    <= 7'h01;
            r_i       <= '0;
            r_ack     <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= Start;
            r_pre_len <= w_pre_len_nxt;
            r_taps    <= w_taps_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_i       <= w_i_nxt;
            r_ack     <= w_ack_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

endmodule
